// File: rtl/codec_intf.sv
// I2S codec bridge: generates MCLK/SCLK/LRCLK, deserializes ADC data, serializes DAC data.
// Latency: rx pair presented 1 clk after right LSB sampled; tx MSB on SDin 16 clks after snapshot.
// No backpressure: fixed-rate stream, valid is a one-cycle strobe once per 1024-clk frame.
module codec_intf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SDout,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic        MCLK,
  output logic        SCLK,
  output logic        LRCLK,
  output logic        SDin,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        valid
);

  // Frame counter: one LRCLK period is 1024 clks, each half holds 32 SCLK slots.
  logic [9:0]  cnt;
  logic [4:0]  slot;

  // Receive path state
  logic [15:0] rx_shft;
  logic [15:0] lft_hold;

  // Transmit path state
  logic [15:0] tx_shft;
  logic [15:0] rht_buf;

  // Decoded edge qualifiers
  logic        rx_sample;
  logic        tx_edge;
  logic        tx_data_slot;
  logic        lft_done;
  logic        pair_done;
  logic        lft_load;
  logic        rht_load;

  assign slot = cnt[8:4];

  // Codec clocks are plain counter bits so they are glitch-free flop outputs.
  assign MCLK  = cnt[1];
  assign SCLK  = cnt[3];
  assign LRCLK = cnt[9];

  // SCLK rising edge happens on the clk edge leaving cnt[3:0]==7; slot 0 is the I2S delay bit.
  assign rx_sample    = (cnt[3:0] == 4'h7) && (slot >= 5'd1) && (slot <= 5'd16);
  // SCLK falling edge happens on the clk edge leaving cnt[3:0]==F.
  assign tx_edge      = (cnt[3:0] == 4'hF);
  // Driving on the slot N falling edge puts the bit in slot N+1, so slots 0..15 carry data.
  assign tx_data_slot = (slot <= 5'd15);
  assign lft_done     = (cnt == 10'h108);
  assign pair_done    = (cnt == 10'h308);
  assign lft_load     = (cnt == 10'h3FF);
  assign rht_load     = (cnt == 10'h1FF);

  // Free-running frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 10'd0;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

  // Receive shift register: collect 16 bits MSB first in each half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shft <= 16'd0;
    end else if (rx_sample) begin
      rx_shft <= {rx_shft[14:0], SDout};
    end
  end

  // Park the left word until the right word completes so both are presented together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_hold <= 16'd0;
    end else if (lft_done) begin
      lft_hold <= rx_shft;
    end
  end

  // Present the received pair with a one-cycle strobe; outputs hold between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_in <= 16'd0;
      rht_in <= 16'd0;
      valid  <= 1'b0;
    end else if (pair_done) begin
      lft_in <= lft_hold;
      rht_in <= rx_shft;
      valid  <= 1'b1;
    end else begin
      valid  <= 1'b0;
    end
  end

  // Right sample is snapshotted with the left one so the pair stays coherent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rht_buf <= 16'd0;
    end else if (lft_load) begin
      rht_buf <= rht_out;
    end
  end

  // Transmit shifter: loads win over shifts; loads fall on slot-31 edges where SDin idles at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= 16'd0;
      SDin    <= 1'b0;
    end else if (lft_load) begin
      tx_shft <= lft_out;
      SDin    <= 1'b0;
    end else if (rht_load) begin
      tx_shft <= rht_buf;
      SDin    <= 1'b0;
    end else if (tx_edge) begin
      if (tx_data_slot) begin
        SDin    <= tx_shft[15];
        tx_shft <= {tx_shft[14:0], 1'b0};
      end else begin
        SDin    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_codec_intf.sv
// Directed bench for codec_intf: clocks, receive deserializer, transmit serializer, resets.
// Latency: checks first valid at 777 clks after release and SDin slot alignment per frame.
// No backpressure: a codec model drives SDout and decodes SDin from a cycle reference.
module tb_codec_intf;

  logic        clk;
  logic        rst_n;
  logic        SDout;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        SDin;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;

  int checks;
  int errors;

  // Clk edges since reset release; low 10 bits match the codec frame position
  logic [31:0] tcyc;

  // Codec ADC stimulus per frame, and DAC words decoded per half (index = frame*2 + half)
  logic [15:0] src_l [0:7];
  logic [15:0] src_r [0:7];
  logic [15:0] dec   [0:15];
  logic        zbad  [0:15];

  codec_intf dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .SDout   (SDout),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .MCLK    (MCLK),
    .SCLK    (SCLK),
    .LRCLK   (LRCLK),
    .SDin    (SDin),
    .lft_in  (lft_in),
    .rht_in  (rht_in),
    .valid   (valid)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Cycle reference
  initial begin
    tcyc = 32'd0;
    forever begin
      @(posedge clk);
      if (rst_n) tcyc = tcyc + 32'd1;
    end
  end

  // Codec ADC model: bit for slot s (1..16) is word[16-s], changed away from SCLK rise
  initial begin
    logic [9:0]  c;
    logic [15:0] w;
    int          s;
    int          f;
    SDout = 1'b0;
    forever begin
      @(negedge clk);
      c = tcyc[9:0];
      f = int'(tcyc >> 10);
      s = int'(c[8:4]);
      if (s >= 1 && s <= 16 && f < 8) begin
        w = c[9] ? src_r[f] : src_l[f];
        SDout = w[16 - s];
      end else begin
        SDout = 1'b0;
      end
    end
  end

  // Codec DAC model: sample SDin at SCLK rise, collect slots 1..16, flag any 1 in other slots
  initial begin
    logic [9:0]  c;
    logic [15:0] acc;
    int          s;
    int          idx;
    acc = 16'd0;
    forever begin
      @(negedge clk);
      c   = tcyc[9:0];
      s   = int'(c[8:4]);
      idx = int'(tcyc >> 10) * 2 + (c[9] ? 1 : 0);
      if (c[3:0] == 4'h7 && idx < 16) begin
        if (s >= 1 && s <= 16) begin
          acc = {acc[14:0], SDin};
          if (s == 16) dec[idx] = acc;
        end else if (SDin !== 1'b0) begin
          zbad[idx] = 1'b1;
        end
      end
    end
  end

  // Pulse reset and release on a falling edge; the release edge is cycle 0 of the reference
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tcyc  = 32'd0;
    for (int k = 0; k < 16; k++) begin
      dec[k]  = 16'd0;
      zbad[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (MCLK !== 1'b0)      begin errors++; $display("FAIL reset_mclk got %b exp 0", MCLK); end
    checks++; if (SCLK !== 1'b0)      begin errors++; $display("FAIL reset_sclk got %b exp 0", SCLK); end
    checks++; if (LRCLK !== 1'b0)     begin errors++; $display("FAIL reset_lrclk got %b exp 0", LRCLK); end
    checks++; if (SDin !== 1'b0)      begin errors++; $display("FAIL reset_sdin got %b exp 0", SDin); end
    checks++; if (lft_in !== 16'h0)   begin errors++; $display("FAIL reset_lft_in got %h exp 0000", lft_in); end
    checks++; if (rht_in !== 16'h0)   begin errors++; $display("FAIL reset_rht_in got %h exp 0000", rht_in); end
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
  endtask

  task automatic test_clocks();
    int m_hi, m_rise, m_first, m_last, m_badgap;
    int s_hi, s_rise, s_first;
    int l_hi, l_rise0, l_rise1, l_fall;
    logic pm, ps, pl;
    m_hi = 0; m_rise = 0; m_first = -1; m_last = -1; m_badgap = 0;
    s_hi = 0; s_rise = 0; s_first = -1;
    l_hi = 0; l_rise0 = -1; l_rise1 = -1; l_fall = -1;
    pm = 1'b0; ps = 1'b0; pl = 1'b0;
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      if (MCLK === 1'b1) m_hi++;
      if (SCLK === 1'b1) s_hi++;
      if (LRCLK === 1'b1) l_hi++;
      if (MCLK === 1'b1 && pm === 1'b0) begin
        if (m_first < 0) m_first = i;
        if (m_last >= 0 && i - m_last != 4) m_badgap++;
        m_last = i;
        m_rise++;
      end
      if (SCLK === 1'b1 && ps === 1'b0) begin
        if (s_first < 0) s_first = i;
        s_rise++;
      end
      if (LRCLK === 1'b1 && pl === 1'b0) begin
        if (l_rise0 < 0) l_rise0 = i; else if (l_rise1 < 0) l_rise1 = i;
      end
      if (LRCLK === 1'b0 && pl === 1'b1 && l_fall < 0) l_fall = i;
      pm = MCLK; ps = SCLK; pl = LRCLK;
      @(negedge clk);
    end
    checks++; if (m_first != 2)     begin errors++; $display("FAIL mclk_first_rise got %0d exp 2", m_first); end
    checks++; if (m_rise != 512)    begin errors++; $display("FAIL mclk_rises got %0d exp 512", m_rise); end
    checks++; if (m_badgap != 0)    begin errors++; $display("FAIL mclk_period bad_gaps %0d exp 0", m_badgap); end
    checks++; if (m_hi != 1024)     begin errors++; $display("FAIL mclk_duty high %0d exp 1024", m_hi); end
    checks++; if (s_first != 8)     begin errors++; $display("FAIL sclk_first_rise got %0d exp 8", s_first); end
    checks++; if (s_rise != 128)    begin errors++; $display("FAIL sclk_rises got %0d exp 128", s_rise); end
    checks++; if (s_hi != 1024)     begin errors++; $display("FAIL sclk_duty high %0d exp 1024", s_hi); end
    checks++; if (l_rise0 != 512)   begin errors++; $display("FAIL lrclk_first_rise got %0d exp 512", l_rise0); end
    checks++; if (l_fall != 1024)   begin errors++; $display("FAIL lrclk_fall got %0d exp 1024", l_fall); end
    checks++; if (l_rise1 != 1536)  begin errors++; $display("FAIL lrclk_second_rise got %0d exp 1536", l_rise1); end
    checks++; if (l_hi != 1024)     begin errors++; $display("FAIL lrclk_duty high %0d exp 1024", l_hi); end
  endtask

  task automatic test_receive();
    int nv, t0, t1, wide;
    logic [15:0] l0, r0, l1, r1;
    logic pv;
    nv = 0; t0 = -1; t1 = -1; wide = 0; pv = 1'b0;
    l0 = 16'h0; r0 = 16'h0; l1 = 16'h0; r1 = 16'h0;
    src_l[0] = 16'hA5C3; src_r[0] = 16'h1234;
    src_l[1] = 16'h0FF0; src_r[1] = 16'hF00F;
    do_reset();
    for (int i = 0; i < 2048; i++) begin
      if (valid === 1'b1) begin
        if (pv === 1'b1) wide++;
        if (nv == 0) begin t0 = i; l0 = lft_in; r0 = rht_in; end
        else if (nv == 1) begin t1 = i; l1 = lft_in; r1 = rht_in; end
        nv++;
      end
      if (i == 1000 || i == 1800) begin
        checks++;
        if (lft_in !== 16'hA5C3 || rht_in !== 16'h1234) begin
          errors++; $display("FAIL rx_hold_%0d got %h/%h exp a5c3/1234", i, lft_in, rht_in);
        end
      end
      pv = valid;
      @(negedge clk);
    end
    checks++; if (t0 != 777)        begin errors++; $display("FAIL rx_first_valid_time got %0d exp 777", t0); end
    checks++; if (l0 !== 16'hA5C3)  begin errors++; $display("FAIL rx_left got %h exp a5c3", l0); end
    checks++; if (r0 !== 16'h1234)  begin errors++; $display("FAIL rx_right got %h exp 1234", r0); end
    checks++; if (wide != 0)        begin errors++; $display("FAIL rx_valid_width extra_cycles %0d exp 0", wide); end
    checks++; if (nv != 2)          begin errors++; $display("FAIL rx_valid_count got %0d exp 2", nv); end
    checks++; if (t1 != 1801 || l1 !== 16'h0FF0 || r1 !== 16'hF00F) begin
      errors++; $display("FAIL rx_second_frame got t=%0d %h/%h exp t=1801 0ff0/f00f", t1, l1, r1);
    end
  endtask

  task automatic test_transmit();
    int nz;
    lft_out = 16'h8001; rht_out = 16'h7FFE;
    do_reset();
    repeat (3072) @(negedge clk);
    checks++; if (dec[0] !== 16'h0000) begin errors++; $display("FAIL tx_frame0_left got %h exp 0000", dec[0]); end
    checks++; if (dec[2] !== 16'h8001) begin errors++; $display("FAIL tx_frame1_left got %h exp 8001", dec[2]); end
    checks++; if (dec[3] !== 16'h7FFE) begin errors++; $display("FAIL tx_frame1_right got %h exp 7ffe", dec[3]); end
    checks++; if (dec[4] !== 16'h8001) begin errors++; $display("FAIL tx_frame2_left got %h exp 8001", dec[4]); end
    checks++; if (dec[5] !== 16'h7FFE) begin errors++; $display("FAIL tx_frame2_right got %h exp 7ffe", dec[5]); end
    nz = 0;
    for (int k = 0; k < 6; k++) if (zbad[k] !== 1'b0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL tx_idle_slots nonzero_halves %0d exp 0", nz); end
  endtask

  task automatic test_snapshot();
    lft_out = 16'h8001; rht_out = 16'h7FFE;
    do_reset();
    repeat (1024 + 256) @(negedge clk);
    rht_out = 16'h0F0F;
    lft_out = 16'h1111;
    repeat (3072 - 1024 - 256) @(negedge clk);
    checks++; if (dec[2] !== 16'h8001) begin errors++; $display("FAIL snap_left_held got %h exp 8001", dec[2]); end
    checks++; if (dec[3] !== 16'h7FFE) begin errors++; $display("FAIL snap_right_held got %h exp 7ffe", dec[3]); end
    checks++; if (dec[4] !== 16'h1111) begin errors++; $display("FAIL snap_left_next got %h exp 1111", dec[4]); end
    checks++; if (dec[5] !== 16'h0F0F) begin errors++; $display("FAIL snap_right_next got %h exp 0f0f", dec[5]); end
  endtask

  task automatic test_back_to_back();
    int nv;
    int tv [0:7];
    logic [15:0] lv [0:7];
    logic [15:0] rv [0:7];
    logic [15:0] el [0:3];
    logic [15:0] er [0:3];
    el[0] = 16'hFFFF; er[0] = 16'h0000;
    el[1] = 16'h0001; er[1] = 16'h8000;
    el[2] = 16'h5A5A; er[2] = 16'hA5A5;
    el[3] = 16'h7FFF; er[3] = 16'h8001;
    for (int k = 0; k < 4; k++) begin src_l[k] = el[k]; src_r[k] = er[k]; end
    nv = 0;
    do_reset();
    for (int i = 0; i < 4096; i++) begin
      if (valid === 1'b1) begin
        if (nv < 8) begin tv[nv] = i; lv[nv] = lft_in; rv[nv] = rht_in; end
        nv++;
      end
      @(negedge clk);
    end
    checks++; if (nv != 4) begin errors++; $display("FAIL b2b_valid_count got %0d exp 4", nv); end
    for (int k = 0; k < 4 && k < nv; k++) begin
      checks++;
      if (tv[k] != 777 + 1024 * k || lv[k] !== el[k] || rv[k] !== er[k]) begin
        errors++;
        $display("FAIL b2b_frame%0d got t=%0d %h/%h exp t=%0d %h/%h",
                 k, tv[k], lv[k], rv[k], 777 + 1024 * k, el[k], er[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int nv, t0;
    logic [15:0] l0, r0;
    src_l[0] = 16'h1357; src_r[0] = 16'h2468;
    src_l[1] = 16'hCAFE; src_r[1] = 16'hBEEF;
    nv = 0;
    do_reset();
    for (int i = 0; i < 1024 + 16'h250; i++) begin
      if (valid === 1'b1) nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 1 || lft_in !== 16'h1357 || rht_in !== 16'h2468) begin
      errors++; $display("FAIL mid_pre_frame got n=%0d %h/%h exp n=1 1357/2468", nv, lft_in, rht_in);
    end
    rst_n = 1'b0;
    tcyc  = 32'd0;
    #1;
    checks++;
    if (lft_in !== 16'h0 || rht_in !== 16'h0 || SDin !== 1'b0 || valid !== 1'b0 || LRCLK !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear got %h/%h sdin=%b valid=%b lrclk=%b exp all 0",
                         lft_in, rht_in, SDin, valid, LRCLK);
    end
    src_l[0] = 16'h4B1D; src_r[0] = 16'hD00D;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nv = 0; t0 = -1; l0 = 16'h0; r0 = 16'h0;
    for (int i = 0; i < 1024; i++) begin
      if (valid === 1'b1) begin
        if (nv == 0) begin t0 = i; l0 = lft_in; r0 = rht_in; end
        nv++;
      end
      @(negedge clk);
    end
    checks++; if (nv != 1 || t0 != 777) begin errors++; $display("FAIL mid_post_valid got n=%0d t=%0d exp n=1 t=777", nv, t0); end
    checks++; if (l0 !== 16'h4B1D || r0 !== 16'hD00D) begin
      errors++; $display("FAIL mid_post_data got %h/%h exp 4b1d/d00d", l0, r0);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b1;
    lft_out = 16'h0;
    rht_out = 16'h0;
    for (int k = 0; k < 8; k++) begin src_l[k] = 16'h0; src_r[k] = 16'h0; end
    for (int k = 0; k < 16; k++) begin dec[k] = 16'h0; zbad[k] = 1'b0; end
    test_reset();
    test_clocks();
    test_receive();
    test_transmit();
    test_snapshot();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
